trigger_bus_arb: RTL and testbench
==================================

Name: trigger_bus_arb

Overview:
- Round-robin arbiter that shares the trigger's write-only configuration bus (bus_wvalid/bus_wready/bus_waddr/bus_wdata) between RN write masters, e.g. the host command decoder and the stored-configuration loader.
- Grants one requester at a time. Supports locked bursts so a multi-register trigger setup (matchers, adders, counters, state table) lands atomically.
- Presents a registered, one-entry output stage to the trigger.

Parameters:
BDW, 32, bus data width
BAW, 6, bus address width
RN, 2, number of requesters (2..8)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_wvalid  in  RN  per-requester write valid
req_wready  out  RN  per-requester write ready
req_wlock  in  RN  per-requester burst lock, sampled with each accepted beat
req_waddr  in  RN*BAW  per-requester address, requester i at bits [i*BAW +: BAW]
req_wdata  in  RN*BDW  per-requester data, requester i at bits [i*BDW +: BDW]
grant  out  RN  one-hot current owner, all-zero when idle
bus_wvalid  out  1  write valid to trigger
bus_wready  in  1  write ready from trigger
bus_waddr  out  BAW  write address to trigger
bus_wdata  out  BDW  write data to trigger

Behaviour:
- Reset (async assert, synchronous release at clk edge):
  - grant=0, bus_wvalid=0, bus_waddr=0, bus_wdata=0, req_wready=0.
  - Round-robin pointer ptr=0; state IDLE.
- Output stage:
  - One register, "empty" when bus_wvalid=0.
  - Transfer to trigger occurs when bus_wvalid & bus_wready.
  - bus_waddr/bus_wdata stay stable while bus_wvalid=1 & bus_wready=0.
- Requester handshake:
  - req_wready[i] = grant[i] & (~bus_wvalid | bus_wready). Combinational from registered state and bus_wready only; never depends on req_wvalid.
  - A beat is accepted when req_wvalid[i] & req_wready[i].
  - Accepted beat is loaded into the output register at the next edge, so bus_wvalid=1 one cycle after acceptance.
  - Back-to-back accepts are allowed, giving 1 beat/cycle sustained when bus_wready=1.
- State machine:
  - IDLE: grant=0. If any req_wvalid, select the first valid index scanning ptr, ptr+1, ... modulo RN. Register its grant bit and go to GRANT. The first beat is therefore accepted no earlier than 1 cycle after valid rises; first bus_wvalid appears 2 cycles after request.
  - GRANT, accepted beat with req_wlock=0: release. Clear grant, set ptr to (owner+1) mod RN, go to IDLE. The next grant cannot be issued in the same cycle; there is 1 dead cycle between owners.
  - GRANT, accepted beat with req_wlock=1: keep grant and stay in GRANT.
  - GRANT, no beat accepted: keep grant. This holds both when the owner's req_wvalid=0 (gaps inside a locked burst are legal) and when the output stage is stalled.
- Fairness: the pointer advances only on release. A requester issuing unlocked single writes alternates with the others; no requester waits more than RN-1 grants.
- Rules and boundary conditions:
  - Non-owners always see req_wready=0.
  - Requesters must hold valid/addr/data/lock stable until accepted. The arbiter does not check this.
  - Simultaneous requests in IDLE: resolved purely by ptr order.
  - Output full with bus_wready=0: req_wready=0 and grant held. No beat is lost or duplicated.
  - The last beat of a burst (lock=0) is still pending in the output register at release. It drains independently of later grants; order on the bus equals acceptance order.
  - ptr wraps from RN-1 to 0.
  - Reset mid-burst or with output full: the pending word is discarded and bus_wvalid drops asynchronously; requesters must restart.

Test Plan:
- Single write: RN=2, requester 0 writes addr=0x05 data=0xDEADBEEF lock=0, bus_wready=1 -> req_wready[0] high cycle 1, bus_wvalid=1 cycle 2 with 0x05/0xDEADBEEF for exactly one cycle; grant returns to 0; ptr=1.
- Contention: both requesters continuously issue unlocked writes (r0 data 0xA0.., r1 data 0xB0..) -> bus order strictly alternates, starting with r0 from reset: A0,B0,A1,B1,...; no beat dropped.
- Locked burst: r1 issues 4 beats addr 0x10..0x13 with lock=1,1,1,0 while r0 requests throughout -> four r1 beats contiguous on bus, then r0 granted; r1 inserting a 3-cycle valid gap mid-burst does not lose the grant.
- Backpressure: bus_wready held low 5 cycles with output full -> bus_waddr/bus_wdata stable, req_wready=0; after ready returns, throughput 1 beat/cycle, counts match.
- Reset mid-burst: assert rst between beat 2 and 3 of a locked burst with output full -> bus_wvalid and grant go 0 immediately (before next clk edge); after release, ptr=0 and r0 wins a simultaneous request.
- Randomized ready/valid soak, 10k beats, RN=4 -> scoreboard: every accepted beat appears once on bus in acceptance order; max wait ≤ 3 grants.

Source files
------------

// File: rtl/trigger_bus_arb.sv
// Round-robin arbiter sharing the trigger configuration write bus between
// RN masters, with locked bursts and a registered one-entry output stage.
module trigger_bus_arb #(
  parameter int BDW = 32,
  parameter int BAW = 6,
  parameter int RN  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RN-1:0]     req_wvalid,
  output logic [RN-1:0]     req_wready,
  input  logic [RN-1:0]     req_wlock,
  input  logic [RN*BAW-1:0] req_waddr,
  input  logic [RN*BDW-1:0] req_wdata,
  output logic [RN-1:0]     grant,
  output logic              bus_wvalid,
  input  logic              bus_wready,
  output logic [BAW-1:0]    bus_waddr,
  output logic [BDW-1:0]    bus_wdata
);

  localparam int PW = (RN > 1) ? $clog2(RN) : 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t         state, state_nxt;
  logic [RN-1:0]  grant_nxt;
  logic [PW-1:0]  ptr, ptr_nxt;
  logic [PW-1:0]  owner;
  logic           owner_lock;
  logic [BAW-1:0] owner_addr;
  logic [BDW-1:0] owner_data;
  logic           out_free;
  logic           accept;

  // Output register can take a beat when empty or draining this cycle.
  assign out_free   = ~bus_wvalid | bus_wready;
  assign req_wready = grant & {RN{out_free}};
  assign accept     = |(req_wvalid & req_wready);

  // Decode the one-hot owner and select its write beat.
  always_comb begin
    owner      = '0;
    owner_lock = 1'b0;
    owner_addr = '0;
    owner_data = '0;
    for (int unsigned i = 0; i < RN; i++) begin
      if (grant[i]) begin
        owner      = PW'(i);
        owner_lock = req_wlock[i];
        owner_addr = req_waddr[i*BAW +: BAW];
        owner_data = req_wdata[i*BDW +: BDW];
      end
    end
  end

  // Next-state logic: round-robin pick in IDLE, release on an unlocked beat.
  always_comb begin
    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        for (int unsigned k = 0; k < RN; k++) begin
          sum = {1'b0, ptr} + (PW+1)'(k);
          if (sum >= (PW+1)'(RN)) sum = sum - (PW+1)'(RN);
          idx = sum[PW-1:0];
          if (!found && req_wvalid[idx]) begin
            found     = 1'b1;
            grant_nxt = RN'(1) << idx;
            state_nxt = GRANT;
          end
        end
      end
      GRANT: begin
        if (accept && !owner_lock) begin
          grant_nxt = '0;
          state_nxt = IDLE;
          ptr_nxt   = (owner == PW'(RN-1)) ? '0 : owner + PW'(1);
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // One-entry output stage: load on accept, empty after transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_wvalid <= 1'b0;
      bus_waddr  <= '0;
      bus_wdata  <= '0;
    end else if (accept) begin
      bus_wvalid <= 1'b1;
      bus_waddr  <= owner_addr;
      bus_wdata  <= owner_data;
    end else if (bus_wready) begin
      bus_wvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trigger_bus_arb.sv
// Testbench for trigger_bus_arb: directed scenarios plus a randomized soak,
// checked against a transaction-level round-robin model and a scoreboard.
module tb_trigger_bus_arb;

  localparam int RN  = 4;
  localparam int BAW = 6;
  localparam int BDW = 32;

  typedef struct {
    logic [BAW-1:0] addr;
    logic [BDW-1:0] data;
    logic           lock;
    int unsigned    gap;
  } beat_t;

  typedef struct {
    logic [BAW-1:0] addr;
    logic [BDW-1:0] data;
  } word_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [RN-1:0]     req_wvalid = '0;
  logic [RN-1:0]     req_wready;
  logic [RN-1:0]     req_wlock = '0;
  logic [RN*BAW-1:0] req_waddr = '0;
  logic [RN*BDW-1:0] req_wdata = '0;
  logic [RN-1:0]     grant;
  logic              bus_wvalid;
  logic              bus_wready = 1'b1;
  logic [BAW-1:0]    bus_waddr;
  logic [BDW-1:0]    bus_wdata;

  trigger_bus_arb #(.BDW(BDW), .BAW(BAW), .RN(RN)) dut (
    .clk(clk), .rst(rst),
    .req_wvalid(req_wvalid), .req_wready(req_wready), .req_wlock(req_wlock),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .grant(grant),
    .bus_wvalid(bus_wvalid), .bus_wready(bus_wready),
    .bus_waddr(bus_waddr), .bus_wdata(bus_wdata)
  );

  always #5 clk = ~clk;

  // Requester-side stimulus state
  beat_t       script[RN][$];
  beat_t       cur[RN];
  beat_t       stg[RN];
  bit          cur_v[RN];
  bit          staged[RN];
  int unsigned gcnt[RN];
  bit          acc[RN];
  int          ready_mode;

  // Reference model: current owner, rr pointer, pending output words
  int          m_owner;
  int          m_ptr;
  int unsigned waitc[RN];
  word_t       pend[$];
  word_t       blog[$];
  int unsigned bcyc[$];
  int unsigned cyc;
  int unsigned n_acc;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < RN; i++) begin
      if (acc[i]) cur_v[i] = 1'b0;
      acc[i] = 1'b0;
      if (!cur_v[i]) begin
        if (!staged[i] && script[i].size() > 0) begin
          stg[i]    = script[i].pop_front();
          staged[i] = 1'b1;
          gcnt[i]   = stg[i].gap;
        end
        if (staged[i]) begin
          if (gcnt[i] == 0) begin
            cur[i]    = stg[i];
            cur_v[i]  = 1'b1;
            staged[i] = 1'b0;
          end else begin
            gcnt[i]--;
          end
        end
      end
      req_wvalid[i]           = cur_v[i];
      req_wlock[i]            = cur_v[i] ? cur[i].lock : 1'b0;
      req_waddr[i*BAW +: BAW] = cur[i].addr;
      req_wdata[i*BDW +: BDW] = cur[i].data;
    end
    case (ready_mode)
      0:       bus_wready = 1'b1;
      1:       bus_wready = ($urandom_range(0, 3) != 0);
      default: bus_wready = 1'b0;
    endcase
  endtask

  // Compare DUT against the model for this cycle, then advance the model.
  task automatic model_step();
    logic [RN-1:0] eg;
    logic [RN-1:0] er;
    bit            free;
    word_t         w;
    int            j;
    eg   = (m_owner < 0) ? '0 : (RN'(1) << m_owner);
    free = (pend.size() == 0) || bus_wready;
    er   = (free && m_owner >= 0) ? eg : '0;
    check_eq("grant", grant, eg);
    check_eq("req_wready", req_wready, er);
    check_eq("bus_wvalid", bus_wvalid, pend.size() != 0);
    if (pend.size() != 0) begin
      check_eq("bus_waddr", bus_waddr, pend[0].addr);
      check_eq("bus_wdata", bus_wdata, pend[0].data);
    end
    if (bus_wvalid && bus_wready) begin
      w.addr = bus_waddr;
      w.data = bus_wdata;
      blog.push_back(w);
      bcyc.push_back(cyc);
    end
    if (pend.size() != 0 && bus_wready) void'(pend.pop_front());
    if (m_owner >= 0) begin
      if (er[m_owner] && cur_v[m_owner]) begin
        acc[m_owner] = 1'b1;
        n_acc++;
        w.addr = cur[m_owner].addr;
        w.data = cur[m_owner].data;
        pend.push_back(w);
        if (!cur[m_owner].lock) begin
          m_ptr   = (m_owner + 1) % RN;
          m_owner = -1;
        end
      end
    end else begin
      for (int k = 0; k < RN; k++) begin
        j = (m_ptr + k) % RN;
        if (m_owner < 0 && cur_v[j]) begin
          m_owner = j;
          for (int o = 0; o < RN; o++) begin
            if (o != j) begin
              if (cur_v[o]) waitc[o]++;
              else waitc[o] = 0;
            end
          end
          check_eq("max_wait", waitc[j] <= RN - 1, 1'b1);
          waitc[j] = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < RN; i++) begin
      script[i].delete();
      cur_v[i]  = 1'b0;
      staged[i] = 1'b0;
      acc[i]    = 1'b0;
      gcnt[i]   = 0;
      waitc[i]  = 0;
      cur[i]    = '{addr: '0, data: '0, lock: 1'b0, gap: 0};
    end
    req_wvalid = '0;
    req_wlock  = '0;
    req_waddr  = '0;
    req_wdata  = '0;
    bus_wready = 1'b1;
    pend.delete();
    blog.delete();
    bcyc.delete();
    m_owner = -1;
    m_ptr   = 0;
    n_acc   = 0;
    #1;
    check_eq("rst_grant", grant, '0);
    check_eq("rst_bus_wvalid", bus_wvalid, 1'b0);
    check_eq("rst_req_wready", req_wready, '0);
    check_eq("rst_bus_waddr", bus_waddr, '0);
    check_eq("rst_bus_wdata", bus_wdata, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic bit all_done();
    bit d;
    d = (pend.size() == 0);
    for (int i = 0; i < RN; i++)
      if (script[i].size() != 0 || staged[i] || cur_v[i]) d = 1'b0;
    return d;
  endfunction

  task automatic run_drain(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!all_done() && n < budget) begin
      cycle();
      n++;
    end
    check_eq({tag, "_drained"}, all_done(), 1'b1);
    repeat (2) cycle();
  endtask

  task automatic add_beat(input int r, input int unsigned a, input int unsigned d,
                          input bit l, input int unsigned g);
    beat_t b;
    b.addr = BAW'(a);
    b.data = d;
    b.lock = l;
    b.gap  = g;
    script[r].push_back(b);
  endtask

  initial begin
    ready_mode = 0;
    #2;

    // Single unlocked write from requester 0
    do_reset();
    add_beat(0, 'h05, 32'hDEADBEEF, 1'b0, 0);
    drive_inputs();
    cycle();
    check_eq("sw_grant_c1", grant, 4'b0001);
    check_eq("sw_ready_c1", req_wready, 4'b0001);
    cycle();
    check_eq("sw_valid_c2", bus_wvalid, 1'b1);
    check_eq("sw_addr_c2", bus_waddr, 6'h05);
    check_eq("sw_data_c2", bus_wdata, 32'hDEADBEEF);
    check_eq("sw_grant_c2", grant, '0);
    cycle();
    check_eq("sw_valid_c3", bus_wvalid, 1'b0);
    run_drain("sw", 20);
    check_eq("sw_count", blog.size(), 1);

    // Contention: two requesters with unlocked singles alternate from r0
    do_reset();
    for (int n = 0; n < 8; n++) begin
      add_beat(0, n, 32'hA0 + n, 1'b0, 0);
      add_beat(1, 'h20 + n, 32'hB0 + n, 1'b0, 0);
    end
    drive_inputs();
    run_drain("cont", 200);
    check_eq("cont_count", blog.size(), 16);
    for (int k = 0; k < 16 && k < blog.size(); k++)
      check_eq("cont_order", blog[k].data, ((k % 2) ? 32'hB0 : 32'hA0) + k / 2);

    // Locked burst from r1 with a 3-cycle gap, r0 requesting throughout
    do_reset();
    for (int n = 0; n < 3; n++) add_beat(0, 'h20 + n, 32'hC0 + n, 1'b0, 0);
    add_beat(1, 'h10, 32'hD0, 1'b1, 0);
    add_beat(1, 'h11, 32'hD1, 1'b1, 0);
    add_beat(1, 'h12, 32'hD2, 1'b1, 3);
    add_beat(1, 'h13, 32'hD3, 1'b0, 0);
    drive_inputs();
    run_drain("lock", 200);
    begin
      int unsigned exp_a[7] = '{'h20, 'h10, 'h11, 'h12, 'h13, 'h21, 'h22};
      check_eq("lock_count", blog.size(), 7);
      for (int k = 0; k < 7 && k < blog.size(); k++)
        check_eq("lock_order", blog[k].addr, exp_a[k][BAW-1:0]);
    end

    // Backpressure: output full with bus_wready low, then full-rate drain
    do_reset();
    ready_mode = 2;
    for (int n = 0; n < 8; n++) add_beat(0, 'h30 + n, 32'h1000 + n, n < 7, 0);
    drive_inputs();
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (k >= 2) begin
        check_eq("bp_valid", bus_wvalid, 1'b1);
        check_eq("bp_addr_stable", bus_waddr, 6'h30);
        check_eq("bp_data_stable", bus_wdata, 32'h1000);
        check_eq("bp_req_wready", req_wready, '0);
      end
    end
    ready_mode = 0;
    bus_wready = 1'b1;
    run_drain("bp", 100);
    check_eq("bp_count", blog.size(), 8);
    if (blog.size() == 8) check_eq("bp_rate", bcyc[7] - bcyc[0], 7);
    for (int k = 0; k < 8 && k < blog.size(); k++)
      check_eq("bp_order", blog[k].addr, BAW'(6'h30 + k));

    // Reset in the middle of a locked burst with output full
    do_reset();
    add_beat(1, 'h10, 32'hE0, 1'b1, 0);
    add_beat(1, 'h11, 32'hE1, 1'b1, 0);
    add_beat(1, 'h12, 32'hE2, 1'b1, 0);
    add_beat(1, 'h13, 32'hE3, 1'b0, 0);
    drive_inputs();
    for (int k = 0; k < 20 && n_acc < 2; k++) cycle();
    check_eq("mr_two_accepted", n_acc, 2);
    check_eq("mr_full_before", bus_wvalid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mr_async_wvalid", bus_wvalid, 1'b0);
    check_eq("mr_async_grant", grant, '0);
    do_reset();
    add_beat(0, 'h01, 32'hF0, 1'b0, 0);
    add_beat(1, 'h02, 32'hF1, 1'b0, 0);
    drive_inputs();
    run_drain("mr", 50);
    check_eq("mr_count", blog.size(), 2);
    if (blog.size() == 2) begin
      check_eq("mr_first_r0", blog[0].addr, 6'h01);
      check_eq("mr_second_r1", blog[1].addr, 6'h02);
    end

    // Randomized soak: 10k beats over RN requesters with random ready
    do_reset();
    ready_mode = 1;
    for (int r = 0; r < RN; r++)
      for (int n = 0; n < 2500; n++)
        add_beat(r, $urandom_range(0, 63), $urandom, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    drive_inputs();
    run_drain("soak", 60000);
    check_eq("soak_count", blog.size(), 10000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
